// File: rtl/convolution_output_stage_pkg.sv
// Shared types, widths and saturation helpers for the convolution output stage.
package conv_out_pkg;

   typedef enum logic {PRIME, RUN} state_t;

   localparam int CONV_W    = 48;
   localparam int SAMPLE_W  = 16;
   localparam int MAX_SHIFT = 47;

   localparam logic signed [CONV_W-1:0] SAT_MAX =
      {{(CONV_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
   localparam logic signed [CONV_W-1:0] SAT_MIN =
      {{(CONV_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

   function automatic logic is_sat16(input logic signed [CONV_W-1:0] x);
      return (x > SAT_MAX) || (x < SAT_MIN);
   endfunction

   function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [CONV_W-1:0] x);
      if (x > SAT_MAX) return SAT_MAX[SAMPLE_W-1:0];
      if (x < SAT_MIN) return SAT_MIN[SAMPLE_W-1:0];
      return x[SAMPLE_W-1:0];
   endfunction

endpackage

// File: rtl/convolution_output_stage_if.sv
// Stream, control and status signals of the convolution output stage.
// dry_in exists only when CONV_DRY_MIX_EN is defined.
interface convolution_output_stage_if #(
   parameter int FIFO_DEPTH = 4
);
   import conv_out_pkg::*;

   localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

   logic signed [CONV_W-1:0]   conv_result_in;
   logic                       conv_valid_in;
   logic [5:0]                 shift_in;
   logic                       audio_trigger;
   logic                       clear_flags_in;
`ifdef CONV_DRY_MIX_EN
   logic signed [SAMPLE_W-1:0] dry_in;
`endif
   logic signed [SAMPLE_W-1:0] audio_out;
   logic                       audio_out_valid;
   logic                       sat_flag_out;
   logic                       drop_flag_out;
   logic                       underrun_out;
   logic [LEVEL_W-1:0]         fifo_level_out;

   modport master (
      output conv_result_in, conv_valid_in, shift_in, audio_trigger, clear_flags_in,
`ifdef CONV_DRY_MIX_EN
      output dry_in,
`endif
      input  audio_out, audio_out_valid, sat_flag_out, drop_flag_out, underrun_out,
             fifo_level_out
   );

   modport slave (
      input  conv_result_in, conv_valid_in, shift_in, audio_trigger, clear_flags_in,
`ifdef CONV_DRY_MIX_EN
      input  dry_in,
`endif
      output audio_out, audio_out_valid, sat_flag_out, drop_flag_out, underrun_out,
             fifo_level_out
   );

endinterface

// File: rtl/sample_fifo.sv
// Synchronous FIFO with registered occupancy; a push at full succeeds only alongside a pop.
module sample_fifo #(
   parameter  int DEPTH   = 4,
   parameter  int WIDTH   = 16,
   localparam int ADDR_W  = $clog2(DEPTH),
   localparam int LEVEL_W = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic               pop,
   input  logic [WIDTH-1:0]   wr_data,
   output logic [WIDTH-1:0]   rd_data,
   output logic               full,
   output logic               empty,
   output logic [LEVEL_W-1:0] level
);

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              push_ok;
   logic              pop_ok;

   assign full    = (level == LEVEL_W'(DEPTH));
   assign empty   = (level == '0);
   assign push_ok = push && (!full || pop);
   assign pop_ok  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wr_data;
   end

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         level <= level + LEVEL_W'(push_ok) - LEVEL_W'(pop_ok);
      end
   end

endmodule

// File: rtl/convolution_output_stage.sv
// Scales, saturates and buffers convolve_audio results, releasing one 16-bit sample per audio_trigger.
// Defining CONV_DRY_MIX_EN adds a dry_in port averaged with the wet sample.
module convolution_output_stage
   import conv_out_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int PRIME_LEVEL = 2
) (
   input logic                       audio_clk,
   input logic                       rst_in,
   convolution_output_stage_if.slave bus
);

   localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [LEVEL_W-1:0] PRIME_THRESH = LEVEL_W'(PRIME_LEVEL);

   logic                       s1_valid;
   logic signed [CONV_W-1:0]   s1_shifted;
   logic [5:0]                 shift_clamped;
   logic signed [SAMPLE_W-1:0] s2_sample;
   logic                       s2_saturated;
   logic                       pop;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic signed [SAMPLE_W-1:0] fifo_head;
   logic [LEVEL_W-1:0]         fifo_level;
   state_t                     state_q;
   state_t                     state_d;
   logic signed [SAMPLE_W-1:0] wet_d;
   logic signed [SAMPLE_W-1:0] held_wet;
   logic signed [SAMPLE_W-1:0] audio_out_d;
   logic signed [SAMPLE_W-1:0] audio_out_q;
   logic                       audio_valid_q;
   logic                       underrun_d;
   logic                       underrun_q;
   logic                       sat_flag_q;
   logic                       drop_flag_q;
   logic                       sat_set;
   logic                       drop_set;
   logic                       mix_saturated;

   assign shift_clamped = (bus.shift_in > 6'(MAX_SHIFT)) ? 6'(MAX_SHIFT) : bus.shift_in;

   always_ff @(posedge audio_clk or negedge rst_in) begin
      if (!rst_in) begin
         s1_valid   <= 1'b0;
         s1_shifted <= '0;
      end else begin
         s1_valid <= bus.conv_valid_in;
         if (bus.conv_valid_in) s1_shifted <= bus.conv_result_in >>> shift_clamped;
      end
   end

   assign s2_sample    = sat16(s1_shifted);
   assign s2_saturated = is_sat16(s1_shifted);

   sample_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (SAMPLE_W)
   ) u_fifo (
      .clk     (audio_clk),
      .rst_n   (rst_in),
      .push    (s1_valid),
      .pop     (pop),
      .wr_data (s2_sample),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   always_ff @(posedge audio_clk or negedge rst_in) begin
      if (!rst_in) state_q <= PRIME;
      else         state_q <= state_d;
   end

   // Pop decisions see only the registered occupancy, never this cycle's push.
   always_comb begin
      state_d    = state_q;
      pop        = 1'b0;
      wet_d      = held_wet;
      underrun_d = 1'b0;
      if (bus.audio_trigger) begin
         case (state_q)
            PRIME: begin
               if (fifo_level >= PRIME_THRESH) begin
                  pop     = 1'b1;
                  wet_d   = fifo_head;
                  state_d = RUN;
               end else begin
                  wet_d = '0;
               end
            end
            RUN: begin
               if (!fifo_empty) begin
                  pop   = 1'b1;
                  wet_d = fifo_head;
               end else begin
                  underrun_d = 1'b1;
                  state_d    = PRIME;
               end
            end
            default: state_d = PRIME;
         endcase
      end
   end

`ifdef CONV_DRY_MIX_EN
   logic signed [SAMPLE_W-1:0] wet_q;
   logic signed [CONV_W-1:0]   wet_ext;
   logic signed [CONV_W-1:0]   dry_ext;
   logic signed [CONV_W-1:0]   mix_sum;

   assign held_wet      = wet_q;
   assign wet_ext       = CONV_W'(wet_d);
   assign dry_ext       = CONV_W'(bus.dry_in);
   assign mix_sum       = (wet_ext >>> 1) + (dry_ext >>> 1);
   assign audio_out_d   = sat16(mix_sum);
   assign mix_saturated = bus.audio_trigger && is_sat16(mix_sum);

   // The held sample on underrun is the last wet value, not the mixed output.
   always_ff @(posedge audio_clk or negedge rst_in) begin
      if (!rst_in)                wet_q <= '0;
      else if (bus.audio_trigger) wet_q <= wet_d;
   end
`else
   assign held_wet      = audio_out_q;
   assign audio_out_d   = wet_d;
   assign mix_saturated = 1'b0;
`endif

   assign sat_set  = (s1_valid && s2_saturated) || mix_saturated;
   assign drop_set = s1_valid && fifo_full && !pop;

   always_ff @(posedge audio_clk or negedge rst_in) begin
      if (!rst_in) begin
         audio_out_q   <= '0;
         audio_valid_q <= 1'b0;
         underrun_q    <= 1'b0;
         sat_flag_q    <= 1'b0;
         drop_flag_q   <= 1'b0;
      end else begin
         audio_valid_q <= bus.audio_trigger;
         underrun_q    <= underrun_d;
         if (bus.audio_trigger) audio_out_q <= audio_out_d;
         sat_flag_q  <= sat_set  ? 1'b1 : (bus.clear_flags_in ? 1'b0 : sat_flag_q);
         drop_flag_q <= drop_set ? 1'b1 : (bus.clear_flags_in ? 1'b0 : drop_flag_q);
      end
   end

   assign bus.audio_out       = audio_out_q;
   assign bus.audio_out_valid = audio_valid_q;
   assign bus.underrun_out    = underrun_q;
   assign bus.sat_flag_out    = sat_flag_q;
   assign bus.drop_flag_out   = drop_flag_q;
   assign bus.fifo_level_out  = fifo_level;

endmodule

// File: tb/tb_convolution_output_stage.sv
// Scoreboard bench for convolution_output_stage: directed scenarios then random traffic against a queue model.
// Also handles builds with CONV_DRY_MIX_EN defined.
module tb_convolution_output_stage;

   localparam int FIFO_DEPTH  = 4;
   localparam int PRIME_LEVEL = 2;
`ifdef CONV_DRY_MIX_EN
   localparam int MIX_SHIFT = 1;
`else
   localparam int MIX_SHIFT = 0;
`endif

   typedef struct {
      int sample;
      bit urun;
   } exp_t;

   logic audio_clk = 1'b0;
   logic rst_in    = 1'b0;
   int   total     = 0;
   int   bad       = 0;

   exp_t exp_q[$];
   int   m_fifo[$];
   bit   m_run;
   int   m_last;
   bit   m_sat;
   bit   m_drop;
   bit   m_pend_valid;
   bit   m_pend_sat;
   int   m_pend_sample;

   convolution_output_stage_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

   convolution_output_stage #(
      .FIFO_DEPTH  (FIFO_DEPTH),
      .PRIME_LEVEL (PRIME_LEVEL)
   ) dut (
      .audio_clk (audio_clk),
      .rst_in    (rst_in),
      .bus       (bus)
   );

   always #5 audio_clk = ~audio_clk;

   function automatic int sat_model(input longint v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return int'(v);
   endfunction

   task automatic check_output(input string name, input logic signed [63:0] actual,
                               input logic signed [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, want %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: a sample lands in the queue one edge after it is accepted, after that edge's trigger.
   always @(posedge audio_clk or negedge rst_in) begin
      if (!rst_in) begin
         m_fifo.delete();
         exp_q.delete();
         m_run        = 1'b0;
         m_last       = 0;
         m_sat        = 1'b0;
         m_drop       = 1'b0;
         m_pend_valid = 1'b0;
      end else begin
         bit     set_sat;
         bit     set_drop;
         bit     urun;
         int     wet;
         int     sh;
         longint v;
         exp_t   e;
         set_sat  = 1'b0;
         set_drop = 1'b0;
         if (bus.audio_trigger) begin
            urun = 1'b0;
            if (!m_run) begin
               if (m_fifo.size() >= PRIME_LEVEL) begin
                  wet   = m_fifo.pop_front();
                  m_run = 1'b1;
               end else begin
                  wet = 0;
               end
            end else if (m_fifo.size() > 0) begin
               wet = m_fifo.pop_front();
            end else begin
               wet   = m_last;
               urun  = 1'b1;
               m_run = 1'b0;
            end
            m_last = wet;
`ifdef CONV_DRY_MIX_EN
            v = longint'(wet >>> 1) + longint'(int'(bus.dry_in) >>> 1);
            if (v > 32767 || v < -32768) set_sat = 1'b1;
            e.sample = sat_model(v);
`else
            e.sample = wet;
`endif
            e.urun = urun;
            exp_q.push_back(e);
         end
         if (m_pend_valid) begin
            if (m_pend_sat) set_sat = 1'b1;
            if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(m_pend_sample);
            else                            set_drop = 1'b1;
         end
         m_sat  = set_sat  ? 1'b1 : (bus.clear_flags_in ? 1'b0 : m_sat);
         m_drop = set_drop ? 1'b1 : (bus.clear_flags_in ? 1'b0 : m_drop);
         m_pend_valid = bus.conv_valid_in;
         if (bus.conv_valid_in) begin
            sh = (bus.shift_in > 47) ? 47 : int'(bus.shift_in);
            v  = bus.conv_result_in;
            v  = v >>> sh;
            m_pend_sat    = (v > 32767) || (v < -32768);
            m_pend_sample = sat_model(v);
         end
      end
   end

   // Monitor: every output pulse must match the head of the expected queue.
   always @(negedge audio_clk) begin
      exp_t e;
      check_output("out_valid", bus.audio_out_valid, exp_q.size() > 0);
      if (bus.audio_out_valid && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_output("audio_out", bus.audio_out, e.sample);
         check_output("underrun", bus.underrun_out, e.urun);
      end else begin
         check_output("underrun_idle", bus.underrun_out, 0);
         exp_q.delete();
      end
      check_output("fifo_level", bus.fifo_level_out, m_fifo.size());
      check_output("sat_flag", bus.sat_flag_out, m_sat);
      check_output("drop_flag", bus.drop_flag_out, m_drop);
   end

   task automatic apply_stimulus(input logic signed [47:0] value, input logic [5:0] shift);
      bus.conv_result_in = value;
      bus.shift_in       = shift;
      bus.conv_valid_in  = 1'b1;
      @(negedge audio_clk);
      bus.conv_valid_in  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge audio_clk);
   endtask

   task automatic clear_flags();
      bus.clear_flags_in = 1'b1;
      @(negedge audio_clk);
      bus.clear_flags_in = 1'b0;
   endtask

   task automatic trigger_expect(input string name, input int exp_out, input bit exp_urun);
      bus.audio_trigger = 1'b1;
      @(negedge audio_clk);
      bus.audio_trigger = 1'b0;
      check_output(name, bus.audio_out, exp_out >>> MIX_SHIFT);
      check_output({name, "_urun"}, bus.underrun_out, exp_urun);
   endtask

   initial begin
      int conv_pct [3];
      int trig_pct [3];
      conv_pct = '{60, 30, 90};
      trig_pct = '{40, 60, 20};
      bus.conv_result_in = '0;
      bus.conv_valid_in  = 1'b0;
      bus.shift_in       = '0;
      bus.audio_trigger  = 1'b0;
      bus.clear_flags_in = 1'b0;
`ifdef CONV_DRY_MIX_EN
      bus.dry_in = '0;
`endif
      idle(3);
      check_output("rst_audio_out", bus.audio_out, 0);
      check_output("rst_valid", bus.audio_out_valid, 0);
      check_output("rst_level", bus.fifo_level_out, 0);
      check_output("rst_sat", bus.sat_flag_out, 0);
      check_output("rst_drop", bus.drop_flag_out, 0);
      rst_in = 1'b1;
      idle(2);

      $display("[TB] unity scaling and priming");
      apply_stimulus(48'sd1048576, 6'd20);
      idle(1);
      trigger_expect("prime_low", 0, 1'b0);
      apply_stimulus(48'sd2097152, 6'd20);
      idle(1);
      check_output("level_two", bus.fifo_level_out, 2);
      trigger_expect("unity_1", 1, 1'b0);
      trigger_expect("unity_2", 2, 1'b0);

      $display("[TB] underrun and re-prime");
      trigger_expect("underrun_hold", 2, 1'b1);
      apply_stimulus(48'sd1048576, 6'd20);
      idle(1);
      trigger_expect("reprime_zero", 0, 1'b0);

      $display("[TB] saturation");
      clear_flags();
      apply_stimulus(48'sd2147483648, 6'd15);
      idle(1);
      check_output("sat_set", bus.sat_flag_out, 1);
      clear_flags();
      check_output("sat_cleared", bus.sat_flag_out, 0);
      apply_stimulus(-48'sd1099511627776, 6'd25);
      idle(1);
      check_output("sat_exact_min", bus.sat_flag_out, 0);
      trigger_expect("drain_1", 1, 1'b0);
      trigger_expect("sat_pos", 32767, 1'b0);
      trigger_expect("sat_neg", -32768, 1'b0);

      $display("[TB] shift clamp");
      apply_stimulus(-48'sd1, 6'd63);
      apply_stimulus(48'sh7FFF_FFFF_FFFF, 6'd63);
      idle(1);
      trigger_expect("clamp_neg", -1, 1'b0);
      trigger_expect("clamp_pos", 0, 1'b0);
      trigger_expect("clamp_urun", 0, 1'b1);

      $display("[TB] overflow and drop");
      for (int k = 1; k <= 5; k++) apply_stimulus(48'(k * 256), 6'd8);
      idle(1);
      check_output("full_level", bus.fifo_level_out, 4);
      check_output("drop_set", bus.drop_flag_out, 1);
      for (int k = 1; k <= 4; k++) trigger_expect($sformatf("order_%0d", k), k, 1'b0);

      $display("[TB] asynchronous reset mid-stream");
      apply_stimulus(48'sd2147483648, 6'd15);
      apply_stimulus(48'sd1280, 6'd8);
      apply_stimulus(48'sd1536, 6'd8);
      idle(1);
      check_output("pre_rst_level", bus.fifo_level_out, 3);
      check_output("pre_rst_sat", bus.sat_flag_out, 1);
      #2 rst_in = 1'b0;
      #1;
      check_output("arst_audio_out", bus.audio_out, 0);
      check_output("arst_valid", bus.audio_out_valid, 0);
      check_output("arst_underrun", bus.underrun_out, 0);
      check_output("arst_level", bus.fifo_level_out, 0);
      check_output("arst_sat", bus.sat_flag_out, 0);
      check_output("arst_drop", bus.drop_flag_out, 0);
      @(negedge audio_clk);
      rst_in = 1'b1;
      idle(1);
      apply_stimulus(48'sd1792, 6'd8);
      idle(1);
      trigger_expect("post_rst_prime", 0, 1'b0);

      $display("[TB] random traffic");
      for (int i = 0; i < 3000; i++) begin
         logic [63:0] r;
         int ph;
         ph = i / 1000;
         r  = {$urandom, $urandom};
         bus.conv_result_in = r[47:0];
         bus.shift_in       = 6'($urandom_range(0, 63));
         bus.conv_valid_in  = ($urandom_range(0, 99) < conv_pct[ph]);
         bus.audio_trigger  = ($urandom_range(0, 99) < trig_pct[ph]);
         bus.clear_flags_in = ($urandom_range(0, 31) == 0);
`ifdef CONV_DRY_MIX_EN
         bus.dry_in = 16'($urandom);
`endif
         @(negedge audio_clk);
      end
      bus.conv_valid_in  = 1'b0;
      bus.audio_trigger  = 1'b0;
      bus.clear_flags_in = 1'b0;
      idle(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
